// File: rtl/midi_parser_if.sv
// MIDI parser bus: incoming UART byte strobe plus the decoded-event
// FIFO head with its ready/valid handshake and sticky overflow flag.
// master = byte source / event consumer, slave = the parser.
interface midi_parser_if;
   logic        midi_send;   // one byte per pulse
   logic [7:0]  midi_data;   // received UART byte
   logic        ev_valid;    // FIFO head holds an event
   logic        ev_ready;    // consumer takes head when ev_valid
   logic [2:0]  ev_type;     // 0 NOTE_OFF .. 6 PITCH_BEND
   logic [3:0]  ev_chan;
   logic [6:0]  ev_d1;
   logic [6:0]  ev_d2;
   logic [13:0] ev_pb;       // {ev_d2, ev_d1}
   logic        overflow;    // sticky, event dropped on full FIFO

   modport master (
      output midi_send, midi_data, ev_ready,
      input  ev_valid, ev_type, ev_chan, ev_d1, ev_d2, ev_pb, overflow
   );

   modport slave (
      input  midi_send, midi_data, ev_ready,
      output ev_valid, ev_type, ev_chan, ev_d1, ev_d2, ev_pb, overflow
   );
endinterface

// File: rtl/midi_parser.sv
// MIDI channel-voice byte parser feeding a small event FIFO.
// Ports: clk, reset (async active-low), bus (midi_parser_if.slave):
//   midi_send/midi_data in, ev_* head-of-FIFO out with ev_valid/ev_ready,
//   sticky overflow. Event appears one cycle after its final byte.
module midi_parser #(
   parameter logic [15:0] CHAN_MASK      = 16'hFFFF,
   parameter int          FIFO_DEPTH     = 4,   // power of two, >= 2
   parameter int          RUNNING_STATUS = 1
) (
   input  logic          clk,
   input  logic          reset,
   midi_parser_if.slave  bus
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int EW = 21;   // {type[2:0], chan[3:0], d1[6:0], d2[6:0]}

   typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2, SKIP} state_t;

   state_t     state, state_nxt;
   logic [3:0] stat_hi, stat_hi_nxt;   // stored status nibble (8..E), 0 = none
   logic [3:0] stat_ch, stat_ch_nxt;
   logic [6:0] d1_q, d1_nxt;

   logic       done;
   logic [2:0] done_type;
   logic [6:0] done_d1;
   logic [6:0] done_d2;

   // ---------------- parser ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         stat_hi <= '0;
         stat_ch <= '0;
         d1_q    <= '0;
      end else begin
         state   <= state_nxt;
         stat_hi <= stat_hi_nxt;
         stat_ch <= stat_ch_nxt;
         d1_q    <= d1_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      stat_hi_nxt = stat_hi;
      stat_ch_nxt = stat_ch;
      d1_nxt      = d1_q;
      done        = 1'b0;
      // status nibble 8..E maps straight onto event type 0..6
      done_type   = stat_hi[2:0];
      done_d1     = d1_q;
      done_d2     = '0;
      if (bus.midi_send) begin
         if (bus.midi_data[7:3] == 5'b11111) begin
            // F8-FF real-time: transparent to the parser
         end else if (bus.midi_data[7:4] == 4'hF) begin
            // system common cancels running status; F0 opens a sysex to skip
            stat_hi_nxt = '0;
            stat_ch_nxt = '0;
            state_nxt   = (bus.midi_data[3:0] == 4'h0) ? SKIP : IDLE;
         end else if (bus.midi_data[7]) begin
            stat_hi_nxt = bus.midi_data[7:4];
            stat_ch_nxt = bus.midi_data[3:0];
            state_nxt   = WAIT_D1;
         end else begin
            unique case (state)
               WAIT_D1: begin
                  d1_nxt = bus.midi_data[6:0];
                  if (stat_hi == 4'hC || stat_hi == 4'hD) begin
                     done      = 1'b1;
                     done_d1   = bus.midi_data[6:0];
                     state_nxt = (RUNNING_STATUS != 0) ? WAIT_D1 : IDLE;
                  end else begin
                     state_nxt = WAIT_D2;
                  end
               end
               WAIT_D2: begin
                  done    = 1'b1;
                  done_d2 = bus.midi_data[6:0];
                  // note-on with zero velocity is a note-off
                  if (stat_hi == 4'h9 && bus.midi_data[6:0] == 7'd0)
                     done_type = 3'd0;
                  state_nxt = (RUNNING_STATUS != 0) ? WAIT_D1 : IDLE;
               end
               default: ;   // IDLE / SKIP drop data bytes
            endcase
         end
      end
   end

   // ---------------- event FIFO ----------------
   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0]   count;
   logic          accept, full, pop, push;

   assign accept = done && CHAN_MASK[stat_ch];
   assign full   = (count == (PW+1)'(FIFO_DEPTH));
   assign pop    = (count != '0) && bus.ev_ready;
   // a pop in the same cycle frees the slot the push needs
   assign push   = accept && (!full || pop);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         bus.overflow <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++)
            mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= {done_type, stat_ch, done_d1, done_d2};
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)
            count <= count + (PW+1)'(1);
         else if (pop && !push)
            count <= count - (PW+1)'(1);
         if (accept && !push)
            bus.overflow <= 1'b1;
      end
   end

   assign bus.ev_valid = (count != '0);
   assign {bus.ev_type, bus.ev_chan, bus.ev_d1, bus.ev_d2} = mem[rd_ptr];
   assign bus.ev_pb = {bus.ev_d2, bus.ev_d1};

endmodule

// File: tb/tb_midi_parser.sv
module tb_midi_parser;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   midi_parser_if b0();
   midi_parser_if b1();

   // instance 0: all channels, running status; instance 1: chan 0 only, no running status
   midi_parser #(.CHAN_MASK(16'hFFFF), .FIFO_DEPTH(4), .RUNNING_STATUS(1)) dut0 (
      .clk(clk), .reset(reset), .bus(b0));
   midi_parser #(.CHAN_MASK(16'h0001), .FIFO_DEPTH(4), .RUNNING_STATUS(0)) dut1 (
      .clk(clk), .reset(reset), .bus(b1));

   localparam int DEPTH = 4;
   logic [15:0] m_mask [2] = '{16'hFFFF, 16'h0001};
   bit          m_rs   [2] = '{1'b1, 1'b0};

   int checks = 0;
   int failures = 0;

   // reference model state (message level, not parser states)
   int  m_st   [2];     // current status byte, -1 none
   int  m_have [2];     // data bytes collected
   int  m_buf0 [2];
   int  occ    [2];     // modelled FIFO occupancy
   bit  ovf    [2];
   bit  pend_v   [2];
   logic [20:0] pend_e [2];
   bit  pend_ovf [2];
   logic [20:0] sb0[$];
   logic [20:0] sb1[$];
   bit  running = 1'b0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_st[k] = -1; m_have[k] = 0; m_buf0[k] = 0;
         occ[k] = 0; ovf[k] = 1'b0;
         pend_v[k] = 1'b0; pend_ovf[k] = 1'b0; pend_e[k] = '0;
      end
      sb0.delete();
      sb1.delete();
   endtask

   // one byte through the message-level model; returns an accepted event
   task automatic model_byte(int k, int b, output bit ev, output logic [20:0] e);
      int hi, ch, need, d1, d2, ty;
      ev = 1'b0; e = '0;
      if (b >= 'hF8) return;
      if (b >= 'hF0) begin m_st[k] = -1; return; end
      if (b >= 'h80) begin m_st[k] = b; m_have[k] = 0; return; end
      if (m_st[k] < 0) return;
      hi = m_st[k] / 16;
      ch = m_st[k] % 16;
      need = (hi == 12 || hi == 13) ? 1 : 2;
      if (need == 2 && m_have[k] == 0) begin
         m_buf0[k] = b; m_have[k] = 1; return;
      end
      d1 = (need == 1) ? b : m_buf0[k];
      d2 = (need == 1) ? 0 : b;
      ty = hi - 8;
      if (hi == 9 && d2 == 0) ty = 0;
      m_have[k] = 0;
      if (!m_rs[k]) m_st[k] = -1;
      if (m_mask[k][ch]) begin
         ev = 1'b1;
         e = {ty[2:0], ch[3:0], d1[6:0], d2[6:0]};
      end
   endtask

   // drive one clock cycle of stimulus; expectations land after the edge
   task automatic cycle(bit send, int b, bit rdy);
      bit ev; logic [20:0] e; bit pop;
      b0.midi_send = send; b0.midi_data = b[7:0]; b0.ev_ready = rdy;
      b1.midi_send = send; b1.midi_data = b[7:0]; b1.ev_ready = rdy;
      for (int k = 0; k < 2; k++) begin
         ev = 1'b0; e = '0;
         if (send) model_byte(k, b, ev, e);
         pop = (occ[k] > 0) && rdy;
         pend_v[k] = 1'b0; pend_e[k] = e; pend_ovf[k] = ovf[k];
         if (ev) begin
            if (occ[k] < DEPTH || pop) pend_v[k] = 1'b1;
            else pend_ovf[k] = 1'b1;
         end
         occ[k] = occ[k] + (pend_v[k] ? 1 : 0) - (pop ? 1 : 0);
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         ovf[k] = pend_ovf[k];
         if (pend_v[k]) begin
            if (k == 0) sb0.push_back(pend_e[k]);
            else        sb1.push_back(pend_e[k]);
         end
      end
      b0.midi_send = 1'b0; b1.midi_send = 1'b0;
   endtask

   task automatic send_seq(int bytes[], bit rdy);
      foreach (bytes[i]) cycle(1'b1, bytes[i], rdy);
   endtask

   task automatic idle(int n, bit rdy);
      for (int i = 0; i < n; i++) cycle(1'b0, 0, rdy);
   endtask

   // monitor: compare DUT head against scoreboard, pop on handshake
   task automatic mon_port(int k, logic v, logic [2:0] t, logic [3:0] c, logic [6:0] d1,
                           logic [6:0] d2, logic [13:0] pb, logic o, logic rdy);
      int sz;
      logic [20:0] h;
      sz = (k == 0) ? sb0.size() : sb1.size();
      chk($sformatf("valid%0d", k), {31'd0, v}, {31'd0, (sz != 0)});
      chk($sformatf("overflow%0d", k), {31'd0, o}, {31'd0, ovf[k]});
      if (sz != 0) begin
         h = (k == 0) ? sb0[0] : sb1[0];
         if (v === 1'b1) begin
            chk($sformatf("event%0d", k), {11'd0, t, c, d1, d2}, {11'd0, h});
            chk($sformatf("pb%0d", k), {18'd0, pb}, {18'd0, h[6:0], h[13:7]});
         end
         if (rdy) begin
            if (k == 0) void'(sb0.pop_front());
            else        void'(sb1.pop_front());
         end
      end
   endtask

   always @(negedge clk) begin
      if (running && reset) begin
         mon_port(0, b0.ev_valid, b0.ev_type, b0.ev_chan, b0.ev_d1, b0.ev_d2, b0.ev_pb,
                  b0.overflow, b0.ev_ready);
         mon_port(1, b1.ev_valid, b1.ev_type, b1.ev_chan, b1.ev_d1, b1.ev_d2, b1.ev_pb,
                  b1.overflow, b1.ev_ready);
      end
   end

   task automatic chk_reset_outputs(string tag);
      chk({tag, "_valid0"}, {31'd0, b0.ev_valid}, 32'd0);
      chk({tag, "_ovf0"},   {31'd0, b0.overflow}, 32'd0);
      chk({tag, "_head0"},  {11'd0, b0.ev_type, b0.ev_chan, b0.ev_d1, b0.ev_d2}, 32'd0);
      chk({tag, "_pb0"},    {18'd0, b0.ev_pb}, 32'd0);
      chk({tag, "_valid1"}, {31'd0, b1.ev_valid}, 32'd0);
      chk({tag, "_ovf1"},   {31'd0, b1.overflow}, 32'd0);
   endtask

   int thr;
   int r, bv;

   initial begin
      b0.midi_send = 1'b0; b0.midi_data = '0; b0.ev_ready = 1'b0;
      b1.midi_send = 1'b0; b1.midi_data = '0; b1.ev_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs("rst_init");
      reset = 1'b1;
      running = 1'b1;

      // note-on chan 3
      send_seq('{'h93, 'h3C, 'h64}, 1'b1);
      idle(3, 1'b1);
      // running status with velocity zero
      send_seq('{'h90, 'h40, 'h7F, 'h40, 'h00}, 1'b1);
      idle(3, 1'b1);
      // pitch bend with real-time byte interleaved, then sysex skipped
      send_seq('{'hE5, 'h00, 'hF8, 'h40}, 1'b1);
      send_seq('{'hF0, 'h12, 'h34, 'hF7, 'hC2, 'h07}, 1'b1);
      idle(3, 1'b1);
      // channel filter
      send_seq('{'hB1, 'h07, 'h64, 'hB0, 'h07, 'h64}, 1'b1);
      idle(3, 1'b1);
      // backpressure: five CCs into a four-deep FIFO
      for (int i = 1; i <= 5; i++) send_seq('{'hB0, i, 16 * i}, 1'b0);
      idle(4, 1'b0);
      idle(8, 1'b1);

      // reset in the middle of a message
      send_seq('{'h90, 'h3C}, 1'b1);
      reset = 1'b0;
      #1;
      chk_reset_outputs("rst_mid");
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      cycle(1'b1, 'h40, 1'b1);
      idle(3, 1'b1);

      // randomized traffic with varying consumer pressure
      thr = 70;
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) thr = $urandom_range(10, 100);
         r = $urandom_range(0, 99);
         if (r < 25)      bv = $urandom_range('h80, 'hEF);
         else if (r < 75) bv = $urandom_range(0, 'h7F);
         else if (r < 85) bv = $urandom_range('hF8, 'hFF);
         else             bv = $urandom_range('hF0, 'hF7);
         cycle($urandom_range(0, 1) == 1, bv, $urandom_range(0, 99) < thr);
      end

      idle(20, 1'b1);
      chk("drained0", sb0.size(), 32'd0);
      chk("drained1", sb1.size(), 32'd0);
      running = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
